// File: rtl/rng_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : rng_sched_pkg
// Brief    : Shared types, defaults and helpers for the RNG mask scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rng_sched_pkg;

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    localparam int c_NREQ_DEF   = 4;
    localparam int c_NBYTES_DEF = 4;
    localparam int c_WARMUP_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : Combinational round-robin picker, first set bit from rr_ptr up.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import rng_sched_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEF,
    parameter int PTR_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt_next,
    output logic             any
);

    logic w_found;

    // Pass one covers rr_ptr..NREQ-1; pass two wraps around to 0..rr_ptr-1.
    always_comb begin
        gnt_next = '0;
        w_found  = 1'b0;
        any      = |req;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req[j] && (PTR_W'(j) >= rr_ptr)) begin
                gnt_next[j] = 1'b1;
                w_found     = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req[j]) begin
                gnt_next[j] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rng_mask_sched.sv
//------------------------------------------------------------------------------
// Module   : rng_mask_sched
// Brief    : Shares one byte-wide RNG among TI mask consumers, round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rng_mask_sched
    import rng_sched_pkg::*;
#(
    parameter int NREQ   = c_NREQ_DEF,
    parameter int NBYTES = c_NBYTES_DEF,
    parameter int WARMUP = c_WARMUP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rng_byte,
    output logic                rng_rd,
    input  logic                rng_hold,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [8*NBYTES-1:0] mask_data,
    output logic                busy
);

    localparam int c_MW    = 8 * NBYTES;
    localparam int c_CNT_W = clog2(NBYTES) + 1;
    localparam int c_PTR_W = clog2(NREQ);

    localparam logic [c_CNT_W-1:0] c_BYTE_LAST = c_CNT_W'(NBYTES - 1);
    localparam logic [15:0]        c_WARM_LAST = 16'(WARMUP - 1);
    localparam sched_state_t       c_RST_STATE = (WARMUP == 0) ? ST_IDLE : ST_WARM;

    sched_state_t         r_state;
    sched_state_t         w_state_next;
    logic [15:0]          r_warm_cnt;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   w_ptr_next;
    logic [NREQ-1:0]      r_gnt;
    logic [c_MW-1:0]      r_mask;
    logic [NREQ-1:0]      w_gnt_next;
    logic                 w_any;
    logic                 w_rd;
    logic                 w_busy;
    logic                 w_done_en;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (r_rr_ptr),
        .gnt_next (w_gnt_next),
        .any      (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_RST_STATE;
        else     r_state <= w_state_next;
    end

    // A held cycle leaves the state where it is, so DONE stretches under hold.
    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        w_busy       = 1'b0;
        w_done_en    = 1'b0;
        case (r_state)
            ST_WARM: begin
                w_busy = 1'b1;
                if (!rng_hold) begin
                    w_rd = 1'b1;
                    if (r_warm_cnt == c_WARM_LAST) w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rng_hold && w_any) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                w_busy = 1'b1;
                if (!rng_hold) begin
                    w_rd = 1'b1;
                    if (r_byte_cnt == c_BYTE_LAST) w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done_en = 1'b1;
                if (!rng_hold) w_state_next = ST_IDLE;
            end
            default: w_state_next = c_RST_STATE;
        endcase
    end

    always_comb begin
        w_ptr_next = r_rr_ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (r_gnt[j]) w_ptr_next = (j == NREQ - 1) ? '0 : c_PTR_W'(j + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_byte_cnt <= '0;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_mask     <= '0;
        end else if (!rng_hold) begin
            case (r_state)
                ST_WARM: r_warm_cnt <= r_warm_cnt + 16'd1;
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt_next;
                        r_byte_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (r_byte_cnt == c_CNT_W'(b)) r_mask[8*b +: 8] <= rng_byte;
                    end
                    r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                end
                ST_DONE: begin
                    r_rr_ptr <= w_ptr_next;
                    r_gnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet during the reset cycle itself.
    assign rng_rd    = w_rd & ~rst;
    assign busy      = w_busy & ~rst;
    assign gnt       = (!rst && (r_state == ST_FILL || r_state == ST_DONE)) ? r_gnt : '0;
    assign done      = (!rst && w_done_en) ? r_gnt : '0;
    assign mask_data = rst ? '0 : r_mask;

endmodule

`default_nettype wire
